// File: rtl/iq_pkg.sv
// Shared types and constants for the packed 16/16 IQ datapath.
package iq_pkg;

  typedef enum logic [1:0] {IDLE, ACC, DUMP} state_t;

  localparam int IQ_HALF = 16;
  localparam int IQ_MAX  = 32767;
  localparam int IQ_MIN  = -32768;

  typedef struct packed {
    logic [IQ_HALF-1:0] i;
    logic [IQ_HALF-1:0] q;
  } iq_t;

  function automatic logic [2*IQ_HALF-1:0] iq_pack(input logic [IQ_HALF-1:0] i,
                                                   input logic [IQ_HALF-1:0] q);
    iq_t w;
    w.i = i;
    w.q = q;
    return w;
  endfunction

  function automatic iq_t iq_unpack(input logic [2*IQ_HALF-1:0] d);
    return iq_t'(d);
  endfunction

endpackage

// File: rtl/iq_round_sat.sv
// Round-half-up, arithmetic right shift and saturate one accumulator component to 16 bits.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module iq_round_sat
  import iq_pkg::*;
#(
  parameter int ACC_WIDTH = 48
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [5:0]           shift,
  output logic [IQ_HALF-1:0]   res,
  output logic                 sat
);

  localparam logic signed [ACC_WIDTH:0] HI = (ACC_WIDTH+1)'(IQ_MAX);
  localparam logic signed [ACC_WIDTH:0] LO = (ACC_WIDTH+1)'(IQ_MIN);

  logic signed [ACC_WIDTH:0] bias;
  logic signed [ACC_WIDTH:0] sum;
  logic signed [ACC_WIDTH:0] r;

  // One guard bit keeps acc + 2^(s-1) from wrapping at the top of the range.
  always_comb begin
    bias = '0;
    if (shift != 6'd0) bias = (ACC_WIDTH+1)'(1) << (shift - 6'd1);
    sum  = $signed({acc[ACC_WIDTH-1], acc}) + bias;
    r    = sum >>> shift;
    res  = r[IQ_HALF-1:0];
    sat  = 1'b0;
    if (r > HI) begin
      res = 16'(IQ_MAX);
      sat = 1'b1;
    end else if (r < LO) begin
      res = 16'(IQ_MIN);
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/iq_integrate_dump.sv
// Coherent integrate-and-dump: sums N complex products, then rounds/scales/saturates to one IQ word.
// Latency: 1 cycle from the Nth accepted sample to m_valid; throughput N samples per N+1 cycles.
// Backpressure: holds in DUMP with s_ready low until the output slot frees; output held while m_ready low.
module iq_integrate_dump
  import iq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 48,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [5:0]            shift,
  input  logic [DATA_WIDTH-1:0] s_re,
  input  logic [DATA_WIDTH-1:0] s_im,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [31:0]           m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  sat
);

  localparam int              EXT       = ACC_WIDTH - DATA_WIDTH;
  localparam logic [5:0]      SHIFT_MAX = 6'(ACC_WIDTH - 1);

  state_t                 state, state_nxt;
  logic                   start_frame, load_out;
  logic                   accept, last, slot_free;
  logic [LEN_WIDTH-1:0]   len_q, cnt;
  logic [5:0]             shift_q;
  logic [ACC_WIDTH-1:0]   acc_re, acc_im;
  logic [ACC_WIDTH-1:0]   sext_re, sext_im;
  logic [IQ_HALF-1:0]     res_re, res_im;
  logic                   sat_re, sat_im;

  assign accept    = s_valid && s_ready;
  assign last      = (cnt == len_q - LEN_WIDTH'(1));
  assign slot_free = !m_valid || m_ready;
  assign sext_re   = {{EXT{s_re[DATA_WIDTH-1]}}, s_re};
  assign sext_im   = {{EXT{s_im[DATA_WIDTH-1]}}, s_im};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      s_ready <= 1'b0;
    end else begin
      state   <= state_nxt;
      s_ready <= (state_nxt == ACC);
    end
  end

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    load_out    = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          start_frame = 1'b1;
          state_nxt   = ACC;
        end
      end
      ACC: begin
        if (accept && last) state_nxt = DUMP;
      end
      DUMP: begin
        if (slot_free) begin
          load_out = 1'b1;
          if (en) begin
            start_frame = 1'b1;
            state_nxt   = ACC;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // start_frame only fires in IDLE/DUMP where s_ready is low, so it never races an accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= '0;
      shift_q <= '0;
      acc_re  <= '0;
      acc_im  <= '0;
      cnt     <= '0;
    end else if (start_frame) begin
      len_q   <= (len == '0) ? LEN_WIDTH'(1) : len;
      shift_q <= (shift > SHIFT_MAX) ? SHIFT_MAX : shift;
      acc_re  <= '0;
      acc_im  <= '0;
      cnt     <= '0;
    end else if (accept) begin
      acc_re  <= acc_re + sext_re;
      acc_im  <= acc_im + sext_im;
      cnt     <= cnt + LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      sat     <= 1'b0;
    end else if (load_out) begin
      m_data  <= iq_pack(res_re, res_im);
      m_valid <= 1'b1;
      sat     <= sat | sat_re | sat_im;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  iq_round_sat #(.ACC_WIDTH(ACC_WIDTH)) u_rs_re (
    .acc   (acc_re),
    .shift (shift_q),
    .res   (res_re),
    .sat   (sat_re)
  );

  iq_round_sat #(.ACC_WIDTH(ACC_WIDTH)) u_rs_im (
    .acc   (acc_im),
    .shift (shift_q),
    .res   (res_im),
    .sat   (sat_im)
  );

endmodule
